// File: rtl/instruction_decode_fsm.sv
// instruction_decode_fsm: issue front end. Fetches a ROM word at IP, splits
// it into {op, dest, src1, src0}, reads both source rows from data RAM and
// offers the decoded instruction to the execution FSM under a
// decode-done / latched handshake. Owns IP and resolves branches.
// Optional build macro: DECODE_HAZARD_INTERLOCK_EN enables the READ-stage
// stall while the execution unit's pending write-back targets a source row.
module instruction_decode_fsm #(
  parameter int              OP_W      = 16,
  parameter int              DADDR_W   = 16,
  parameter int              RADDR_W   = 16,
  parameter int              ROW_W     = 96,
  parameter logic [OP_W-1:0] RETURN_OP = 16'h0001
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        iEnable,
  input  logic [RADDR_W-1:0]          iInitialIP,
  output logic [RADDR_W-1:0]          oInstructionReadAddress,
  input  logic [OP_W+3*DADDR_W-1:0]   iInstruction,
  output logic [DADDR_W-1:0]          oRAMReadAddress0,
  output logic [DADDR_W-1:0]          oRAMReadAddress1,
  input  logic [ROW_W-1:0]            iRAMData0,
  input  logic [ROW_W-1:0]            iRAMData1,
  output logic                        oDecodeDone,
  output logic [OP_W-1:0]             oOperation,
  output logic [DADDR_W-1:0]          oDestination,
  output logic [ROW_W-1:0]            oSource0,
  output logic [ROW_W-1:0]            oSource1,
  input  logic                        iExeLatchedValues,
  input  logic                        iExeBusy,
  input  logic                        iJumpFlag,
  input  logic [RADDR_W-1:0]          iJumpIp,
  input  logic [DADDR_W-1:0]          iLastDestination,
  output logic                        oProgramDone,
  output logic                        oBusy
);

  localparam int                 INS_W  = OP_W + 3*DADDR_W;
  localparam logic [RADDR_W-1:0] IP_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_CAPTURE, S_ISSUE, S_WAIT_BRANCH, S_DRAIN
  } state_t;

  state_t             state, state_nxt;
  logic [RADDR_W-1:0] ip, ip_nxt;
  logic [DADDR_W-1:0] src0, src1;
  logic               hazard;

  assign oInstructionReadAddress = ip;
  assign oRAMReadAddress0        = src0;
  assign oRAMReadAddress1        = src1;

`ifdef DECODE_HAZARD_INTERLOCK_EN
  // Hold READ while the in-flight write-back lands on one of our source rows.
  assign hazard = iExeBusy && ((src0 == iLastDestination) || (src1 == iLastDestination));
`else
  // No interlock: software separates dependent instructions with NOPs.
  logic unused_last_dest;
  assign unused_last_dest = ^iLastDestination;
  assign hazard           = 1'b0;
`endif

  // State and instruction pointer registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      ip    <= '0;
    end else begin
      state <= state_nxt;
      ip    <= ip_nxt;
    end
  end

  // Next-state, IP update and status outputs.
  always_comb begin
    state_nxt    = state;
    ip_nxt       = ip;
    oDecodeDone  = 1'b0;
    oProgramDone = 1'b0;
    oBusy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (iEnable) begin
          ip_nxt    = iInitialIP;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE:  state_nxt = S_READ;
      S_READ:    if (!hazard) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_ISSUE;
      S_ISSUE: begin
        oDecodeDone = 1'b1;
        if (iExeLatchedValues) begin
          if (oOperation == RETURN_OP) begin
            state_nxt = S_DRAIN;
          end else if (oOperation[OP_W-1]) begin
            state_nxt = S_WAIT_BRANCH;
          end else begin
            ip_nxt    = ip + IP_ONE;
            state_nxt = S_FETCH;
          end
        end
      end
      S_WAIT_BRANCH: begin
        // A taken jump wins over the fall-through in the same cycle.
        if (iJumpFlag) begin
          ip_nxt    = iJumpIp;
          state_nxt = S_FETCH;
        end else if (!iExeBusy) begin
          ip_nxt    = ip + IP_ONE;
          state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (!iExeBusy) begin
          oProgramDone = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decoded fields and source rows; held untouched through ISSUE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oOperation   <= '0;
      oDestination <= '0;
      src0         <= '0;
      src1         <= '0;
      oSource0     <= '0;
      oSource1     <= '0;
    end else begin
      if (state == S_DECODE) begin
        oOperation   <= iInstruction[INS_W-1 -: OP_W];
        oDestination <= iInstruction[3*DADDR_W-1 -: DADDR_W];
        src1         <= iInstruction[2*DADDR_W-1 -: DADDR_W];
        src0         <= iInstruction[DADDR_W-1:0];
      end
      if (state == S_CAPTURE) begin
        oSource0 <= iRAMData0;
        oSource1 <= iRAMData1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode_fsm.sv
// tb_instruction_decode_fsm: random programs walked by a reference model that
// fills a scoreboard; a monitor pops on every decode-done/latched handshake.
module tb_instruction_decode_fsm;

  localparam logic [15:0] RET    = 16'h0001;
  localparam logic [95:0] HZ_OLD = 96'h0000_1111_0000_2222_0000_3333;
  localparam logic [95:0] HZ_NEW = 96'hABCD_0001_ABCD_0002_ABCD_0003;
`ifdef DECODE_HAZARD_INTERLOCK_EN
  localparam int HZ_LAT = 8;
  localparam bit HZ_ON  = 1'b1;
`else
  localparam int HZ_LAT = 5;
  localparam bit HZ_ON  = 1'b0;
`endif

  logic        Clock, Reset, iEnable;
  logic [15:0] iInitialIP, oInstructionReadAddress;
  logic [63:0] iInstruction;
  logic [15:0] oRAMReadAddress0, oRAMReadAddress1;
  logic [95:0] iRAMData0, iRAMData1;
  logic        oDecodeDone;
  logic [15:0] oOperation, oDestination;
  logic [95:0] oSource0, oSource1;
  logic        iExeLatchedValues, iExeBusy, iJumpFlag;
  logic [15:0] iJumpIp, iLastDestination;
  logic        oProgramDone, oBusy;

  instruction_decode_fsm dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iInitialIP(iInitialIP),
    .oInstructionReadAddress(oInstructionReadAddress), .iInstruction(iInstruction),
    .oRAMReadAddress0(oRAMReadAddress0), .oRAMReadAddress1(oRAMReadAddress1),
    .iRAMData0(iRAMData0), .iRAMData1(iRAMData1), .oDecodeDone(oDecodeDone),
    .oOperation(oOperation), .oDestination(oDestination),
    .oSource0(oSource0), .oSource1(oSource1),
    .iExeLatchedValues(iExeLatchedValues), .iExeBusy(iExeBusy),
    .iJumpFlag(iJumpFlag), .iJumpIp(iJumpIp), .iLastDestination(iLastDestination),
    .oProgramDone(oProgramDone), .oBusy(oBusy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memories: index by the low 8 address bits, 1-cycle read latency.
  logic [63:0] rom [256];
  logic [95:0] ram [256];
  always @(posedge Clock) begin
    iInstruction <= rom[oInstructionReadAddress[7:0]];
    iRAMData0    <= ram[oRAMReadAddress0[7:0]];
    iRAMData1    <= ram[oRAMReadAddress1[7:0]];
  end

  typedef struct {
    logic [15:0] ip, op, dest, a0, a1;
    logic [95:0] d0, d1;
  } exp_t;
  typedef struct {
    int          lat, kind, busy_n;
    bit          jump, busy_at_jump;
    logic [15:0] tgt;
  } dec_t;

  exp_t sbq[$];
  dec_t decq[$];
  int   total = 0, bad = 0, done_cnt = 0;

  task automatic check(string name, logic [287:0] act, logic [287:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat_pick();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 10 : r;
  endfunction

  task automatic push_exp(logic [15:0] ip);
    logic [63:0] w = rom[ip[7:0]];
    exp_t e;
    e.ip = ip; e.op = w[63:48]; e.dest = w[47:32]; e.a1 = w[31:16]; e.a0 = w[15:0];
    e.d0 = ram[e.a0[7:0]]; e.d1 = ram[e.a1[7:0]];
    sbq.push_back(e);
  endtask

  // Reference: walk the program as the ISA defines it, choosing branch outcomes.
  task automatic walk(logic [15:0] ip0, logic [15:0] last);
    logic [15:0] ip = ip0;
    logic [63:0] w;
    dec_t d;
    int m;
    for (int s = 0; s < 64; s++) begin
      w = rom[ip[7:0]];
      push_exp(ip);
      d.lat = lat_pick(); d.busy_n = $urandom_range(0, 3);
      d.jump = 1'b0; d.busy_at_jump = 1'b0; d.tgt = 16'($urandom);
      if (w[63:48] == RET) begin
        d.kind = 2; decq.push_back(d); break;
      end
      if (w[63]) begin
        d.kind = 1; m = $urandom_range(0, 2);
        d.jump = (m != 2); d.busy_at_jump = (m == 0);
        if (d.jump) begin
          d.tgt = ip + 16'($urandom_range(1, int'(last - ip)));
          ip = d.tgt;
        end else ip = ip + 16'd1;
      end else begin
        d.kind = 0; ip = ip + 16'd1;
      end
      decq.push_back(d);
    end
  endtask

  task automatic recover();
    Reset = 1'b1; @(posedge Clock); #1 Reset = 1'b0;
    sbq.delete(); decq.delete();
    iExeLatchedValues = 0; iExeBusy = 0; iJumpFlag = 0;
  endtask

  // Execution-unit stand-in: consumes the decision list in program order.
  task automatic drive(logic [15:0] ip0);
    dec_t d;
    bit found;
    iInitialIP = ip0; iEnable = 1'b1;
    @(posedge Clock); #1 iEnable = 1'b0;
    while (decq.size() > 0) begin
      d = decq.pop_front(); found = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge Clock);
        if (oDecodeDone) begin found = 1; break; end
      end
      if (!found) begin
        total++; bad++;
        $display("FAIL issue_timeout: got no decode-done expected one within 100 cycles");
        recover(); return;
      end
      for (int i = 0; i < d.lat; i++) @(posedge Clock);
      @(posedge Clock); #1 iExeLatchedValues = 1'b1; iLastDestination = 16'($urandom);
      @(posedge Clock); #1 iExeLatchedValues = 1'b0;
      if (d.kind == 1) begin
        for (int i = 0; i < d.busy_n; i++) begin
          iExeBusy = 1'b1; iJumpIp = 16'($urandom); @(posedge Clock); #1;
        end
        iJumpFlag = d.jump; iJumpIp = d.tgt; iExeBusy = d.busy_at_jump;
        @(posedge Clock); #1 iJumpFlag = 1'b0; iExeBusy = 1'b0;
      end else if (d.kind == 2) begin
        for (int i = 0; i < d.busy_n; i++) begin
          iExeBusy = 1'b1; @(posedge Clock); #1;
        end
        iExeBusy = 1'b0;
        @(negedge Clock); check("done_pulse", oProgramDone, 1);
        @(negedge Clock); check("idle_after_done", {oBusy, oProgramDone}, 0);
      end
    end
  endtask

  // Directed run with the exe unit latching immediately; counts issue latency.
  task automatic direct_run(logic [15:0] ip0, int exp_lat, bit hz);
    int found = 0;
    int dc;
    iExeLatchedValues = 1'b1; iLastDestination = hz ? 16'h0007 : 16'hFFFF;
    iInitialIP = ip0; iEnable = 1'b1;
    @(posedge Clock); #1 iEnable = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      iExeBusy = hz && (k >= 3) && (k <= 5);
      if (hz && k == 6) ram[7] = HZ_NEW;
      if (k == 3) begin iEnable = 1'b1; iInitialIP = 16'h0099; end
      if (k == 4) iEnable = 1'b0;
      @(negedge Clock);
      if (oDecodeDone) begin found = k; break; end
      @(posedge Clock); #1;
    end
    check("issue_latency", found, exp_lat);
    @(posedge Clock); #1 iExeBusy = 1'b0; iEnable = 1'b0;
    if (hz) ram[7] = HZ_NEW;
    @(negedge Clock); check("next_fetch_addr", oInstructionReadAddress, ip0 + 16'd1);
    dc = done_cnt;
    for (int k = 0; k < 30 && oBusy; k++) @(negedge Clock);
    check("program_done_count", done_cnt - dc, 1);
    check("idle_after_return", oBusy, 0);
    iExeLatchedValues = 1'b0;
  endtask

  // Monitor: scoreboard pop on handshake, hold check while ISSUE waits.
  initial begin
    logic [271:0] snap, cur;
    bit prev_dd;
    exp_t e;
    prev_dd = 0; snap = '0;
    forever begin
      @(negedge Clock);
      if (Reset) begin prev_dd = 0; continue; end
      cur = {oInstructionReadAddress, oOperation, oDestination, oRAMReadAddress0,
             oRAMReadAddress1, oSource0, oSource1};
      if (oDecodeDone && prev_dd) check("issue_hold", cur, snap);
      if (oDecodeDone && iExeLatchedValues) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_issue: got op %0h at ip %0h expected none", oOperation, oInstructionReadAddress);
        end else begin
          e = sbq.pop_front();
          check("issue_ip", oInstructionReadAddress, e.ip);
          check("issue_op", oOperation, e.op);
          check("issue_dest", oDestination, e.dest);
          check("issue_addr", {oRAMReadAddress1, oRAMReadAddress0}, {e.a1, e.a0});
          check("issue_src0", oSource0, e.d0);
          check("issue_src1", oSource1, e.d1);
        end
      end
      prev_dd = oDecodeDone && !iExeLatchedValues;
      snap = cur;
      if (oProgramDone) done_cnt++;
    end
  end

  initial begin
    logic [15:0] base, last, op;
    int n;
    exp_t e;
    Reset = 0; iEnable = 0; iInitialIP = 0; iExeLatchedValues = 0; iExeBusy = 0;
    iJumpFlag = 0; iJumpIp = 0; iLastDestination = 16'hFFFF;
    for (int i = 0; i < 256; i++) begin
      rom[i] = {$urandom, $urandom};
      ram[i] = {$urandom, $urandom, $urandom};
    end
    #1 Reset = 1;
    #12;
    check("reset_outputs", {oInstructionReadAddress, oRAMReadAddress0, oRAMReadAddress1,
          oOperation, oDestination, oDecodeDone, oProgramDone, oBusy}, 0);
    check("reset_sources", {oSource0, oSource1}, 0);
    @(posedge Clock); #1 Reset = 0;

    // Start-up latency and field layout.
    rom[8'h10] = {16'h0002, 16'h0005, 16'h0003, 16'h0004};
    rom[8'h11] = {RET, 48'h0};
    push_exp(16'h0010); push_exp(16'h0011);
    direct_run(16'h0010, 5, 1'b0);

    // Source row written back by the in-flight instruction.
    rom[8'h20] = {16'h0003, 16'h0009, 16'h0003, 16'h0007};
    rom[8'h21] = {RET, 48'h0};
    ram[7] = HZ_OLD;
    push_exp(16'h0020);
    e = sbq.pop_back();
    if (HZ_ON) e.d0 = HZ_NEW;
    sbq.push_back(e);
    push_exp(16'h0021);
    direct_run(16'h0020, HZ_LAT, 1'b1);

    // IP wraps from all-ones to zero.
    rom[8'hFF] = {16'h0004, 16'($urandom), 16'($urandom), 16'($urandom)};
    rom[8'h00] = {RET, 16'($urandom), 16'($urandom), 16'($urandom)};
    walk(16'hFFFF, 16'h0000);
    drive(16'hFFFF);

    // Random forward-branching programs ending in RETURN.
    for (int p = 0; p < 40; p++) begin
      base = 16'($urandom_range(64, 180));
      n = $urandom_range(2, 8);
      last = base + 16'(n - 1);
      for (int i = 0; i < n; i++) begin
        if (i == n - 1) op = RET;
        else if ($urandom_range(0, 2) == 0) op = 16'h8000 | 16'($urandom);
        else begin
          op = 16'($urandom) & 16'h7FFF;
          if (op == RET) op = 16'h0002;
        end
        rom[8'(base + 16'(i))] = {op, 16'($urandom), 16'($urandom), 16'($urandom)};
      end
      walk(base, last);
      drive(base);
    end

    // Asynchronous reset while in CAPTURE.
    rom[8'h50] = {16'h0006, 16'h0033, 16'h0022, 16'h0011};
    iInitialIP = 16'h0050; iEnable = 1'b1;
    @(posedge Clock); #1 iEnable = 1'b0;
    repeat (3) @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("reset_in_capture", {oInstructionReadAddress, oRAMReadAddress0, oRAMReadAddress1,
          oOperation, oDestination, oDecodeDone, oProgramDone, oBusy}, 0);
    check("reset_in_capture_src", {oSource0, oSource1}, 0);
    @(posedge Clock); #1 Reset = 1'b0;

    // Normal operation resumes after the abort.
    rom[8'h60] = {16'h0007, 16'($urandom), 16'($urandom), 16'($urandom)};
    rom[8'h61] = {RET, 16'($urandom), 16'($urandom), 16'($urandom)};
    walk(16'h0060, 16'h0061);
    drive(16'h0060);

    repeat (3) @(negedge Clock);
    check("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_decode_fsm.md
# instruction_decode_fsm

Front-end issue unit feeding the execution FSM. Fetches one instruction word per program step from instruction ROM, splits it into opcode/destination/source fields, and reads both source rows from data RAM. It then presents the decoded instruction to the execution FSM under a decode-done/latched handshake. It owns the instruction pointer, resolves branches from the execution unit's jump feedback, and interlocks against the execution unit's pending write-back.

## Interface
Parameters:
- OP_W, 16, opcode width
- DADDR_W, 16, data RAM address width
- RADDR_W, 16, instruction ROM address width
- ROW_W, 96, data row width (three 32-bit channels)
- RETURN_OP, 16'h0001, opcode that ends a program

Ports:
- Clock  in  1  clock; all state on rising edge
- Reset  in  1  asynchronous, active-high
- iEnable  in  1  start pulse, sampled only in IDLE
- iInitialIP  in  RADDR_W  program entry address, loaded on start
- oInstructionReadAddress  out  RADDR_W  ROM address; equals IP register
- iInstruction  in  OP_W+3*DADDR_W  ROM data, valid 1 cycle after address; layout {op, dest, src1, src0}, MSB first
- oRAMReadAddress0 / oRAMReadAddress1  out  DADDR_W  source addresses
- iRAMData0 / iRAMData1  in  ROW_W  RAM read data, valid 1 cycle after address
- oDecodeDone  out  1  decoded instruction valid
- oOperation  out  OP_W;  oDestination  out  DADDR_W;  oSource0 / oSource1  out  ROW_W  registered instruction outputs
- iExeLatchedValues  in  1  execution unit captured outputs this cycle
- iExeBusy  in  1  execution unit waiting on ALU
- iJumpFlag  in  1  branch taken, single-cycle
- iJumpIp  in  RADDR_W  branch target, valid with iJumpFlag
- iLastDestination  in  DADDR_W  destination of in-flight instruction
- oProgramDone  out  1  one-cycle pulse on program completion
- oBusy  out  1  high in every state except IDLE

## Operation
- States: IDLE, FETCH, DECODE, READ, CAPTURE, ISSUE, WAIT_BRANCH, DRAIN.
- IDLE: on iEnable, IP<=iInitialIP -> FETCH.
- FETCH: ROM address = IP -> DECODE.
- DECODE: register iInstruction fields into oOperation/oDestination and internal src0/src1 -> READ.
- READ: oRAMReadAddress0/1 = src0/src1. Hazard = iExeBusy && (src0==iLastDestination || src1==iLastDestination). Hazard: stay in READ. Else -> CAPTURE.
- CAPTURE: oSource0<=iRAMData0, oSource1<=iRAMData1 -> ISSUE.
- ISSUE: oDecodeDone=1; all outputs held stable. Without iExeLatchedValues: stay in ISSUE. With iExeLatchedValues:
  - oOperation==RETURN_OP -> DRAIN.
  - else oOperation[OP_W-1]==1 (branch class) -> WAIT_BRANCH.
  - else IP<=IP+1 -> FETCH.
- WAIT_BRANCH: iJumpFlag -> IP<=iJumpIp, FETCH. Else if !iExeBusy -> IP<=IP+1, FETCH. iJumpFlag wins if both are seen the same cycle.
- DRAIN: wait for !iExeBusy, then pulse oProgramDone -> IDLE.
- IP arithmetic is modulo 2^RADDR_W; IP+1 at all-ones wraps to 0.

## Timing
- Reset: state IDLE; IP, oInstructionReadAddress, oRAMReadAddress0/1, oOperation, oDestination, oSource0/1 all 0; oDecodeDone, oProgramDone, oBusy all 0.
- Reset mid-operation aborts immediately; any partially issued instruction is discarded.
- No-hazard latency: iEnable edge to oDecodeDone high is 5 cycles (FETCH, DECODE, READ, CAPTURE, then ISSUE).
- Sequential issue rate: 5 cycles per instruction, plus handshake wait.
- oDecodeDone is combinational from state == ISSUE. It drops in the cycle after the edge at which iExeLatchedValues=1.
- Hazard stall: READ repeats while hazard holds. The RAM read is re-issued in the first cycle iExeBusy=0, so the write-back edge precedes the read.
- iEnable outside IDLE is ignored.

## Configuration
- DECODE_HAZARD_INTERLOCK_EN defined: READ-stage hazard stall as described.
- DECODE_HAZARD_INTERLOCK_EN undefined: READ always proceeds to CAPTURE in one cycle. Software must insert NOPs between dependent instructions.

## Test plan
- Start: iInitialIP=0x0010, ROM[0x10]={0x0002,0x0005,0x0003,0x0004}, exe latches immediately -> oDecodeDone in cycle 5; oSource0=RAM[4], oSource1=RAM[3], oDestination=5; next fetch address 0x0011.
- Handshake hold: withhold iExeLatchedValues 10 cycles -> oDecodeDone and all outputs constant for 10 cycles; IP advances only after latch.
- Branch taken: branch-class op latched, iJumpFlag=1 with iJumpIp=0x0040 two cycles later -> next oInstructionReadAddress=0x0040.
- Branch not taken: iJumpFlag never asserted, iExeBusy falls -> next fetch is IP+1. Simultaneous iJumpFlag with !iExeBusy -> jump target used.
- Hazard (macro on): src0=iLastDestination=0x0007, iExeBusy high 3 cycles -> READ held 3 extra cycles; oSource0 equals the written-back value. Macro off: no stall; stale value captured.
- Program end and reset: RETURN_OP latched, iExeBusy drops -> single oProgramDone pulse, oBusy=0. Async Reset asserted in CAPTURE -> all outputs 0 with no clock edge.
